// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nn_pkg
// Purpose  : Shared types for the output deserializer.
//            deser_state_e - COLLECT while words are gathered,
//                            FULL while a complete vector waits for the
//                            consumer.
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } deser_state_e;

endpackage : nn_pkg
`default_nettype wire

// File: rtl/output_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : output_deserializer
// Purpose  : Collects numWords serial words of dataWidth bits into one
//            parallel vector and offers it with a valid/ready handshake.
//            With msbFirst=0 the first word lands in the lowest slot of
//            outData; with msbFirst=1 it lands in the highest slot.
//
// Ports    : clk        - single rising-edge clock
//            reset      - synchronous active-low reset
//            clear      - synchronous flush of a partial vector
//            inValid    - serial word present on inData
//            inData     - serial word
//            inReady    - block accepts a word (registered)
//            outValid   - complete vector held (registered)
//            outReady   - consumer accepts the vector
//            outData    - assembled vector, numWords*dataWidth bits
//            wordCount  - words captured so far in the current vector
//            overrun    - sticky: a word was offered while inReady=0
//                         (present only with OUTPUT_DESER_OVERRUN_EN)
//
// Options  : `define OUTPUT_DESER_OVERRUN_EN to add the overrun output.
//
// Revision : 1.0 - initial release
// ============================================================================
module output_deserializer
  import nn_pkg::*;
#(
  parameter int numWords     = 16,
  parameter int dataWidth    = 16,
  parameter int counterWidth = $clog2(numWords),
  parameter int msbFirst     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          inValid,
  input  logic [dataWidth-1:0]          inData,
  output logic                          inReady,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [dataWidth*numWords-1:0] outData,
  output logic [counterWidth-1:0]       wordCount
`ifdef OUTPUT_DESER_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  localparam logic [counterWidth-1:0] LAST_IDX = counterWidth'(numWords - 1);

  deser_state_e                  state_q,     state_d;
  logic [counterWidth-1:0]       count_q,     count_d;
  logic [dataWidth*numWords-1:0] data_q,      data_d;
  logic                          in_ready_q,  in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic [counterWidth-1:0]       slot;

`ifdef OUTPUT_DESER_OVERRUN_EN
  logic                          overrun_q,   overrun_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    data_d      = data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    // Slot written by the current capture; reversed when msbFirst is set.
    if (msbFirst != 0) begin
      slot = LAST_IDX - count_q;
    end else begin
      slot = count_q;
    end

    if (clear) begin
      // Flush wins over any capture or transfer on this edge; slot
      // contents are intentionally kept.
      state_d     = COLLECT;
      count_d     = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (inValid && in_ready_q) begin
            data_d[32'(slot) * dataWidth +: dataWidth] = inData;
            if (count_q == LAST_IDX) begin
              count_d     = '0;
              state_d     = FULL;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              count_d = count_q + counterWidth'(1);
            end
          end
        end
        FULL: begin
          if (out_valid_q && outReady) begin
            state_d     = COLLECT;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = COLLECT;
          count_d     = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

`ifdef OUTPUT_DESER_OVERRUN_EN
  always_comb begin
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end else if (inValid && !in_ready_q) begin
      overrun_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef OUTPUT_DESER_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef OUTPUT_DESER_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign inReady   = in_ready_q;
  assign outValid  = out_valid_q;
  assign outData   = data_q;
  assign wordCount = count_q;
`ifdef OUTPUT_DESER_OVERRUN_EN
  assign overrun   = overrun_q;
`endif

endmodule : output_deserializer
`default_nettype wire

// File: tb/tb_output_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_deserializer
// Purpose  : Directed, table-driven bench for output_deserializer with
//            numWords=4, dataWidth=16. Two instances share all inputs:
//            dut_lsb (msbFirst=0) and dut_msb (msbFirst=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_deserializer;

  localparam int NW = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready_l,  in_ready_m;
  logic          out_valid_l, out_valid_m;
  logic [63:0]   out_data_l,  out_data_m;
  logic [CW-1:0] word_count_l, word_count_m;
`ifdef OUTPUT_DESER_OVERRUN_EN
  logic          overrun_l, overrun_m;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_deserializer #(
    .numWords(NW), .dataWidth(DW), .counterWidth(CW), .msbFirst(0)
  ) dut_lsb (
    .clk(clk), .reset(reset), .clear(clear),
    .inValid(in_valid), .inData(in_data), .inReady(in_ready_l),
    .outValid(out_valid_l), .outReady(out_ready), .outData(out_data_l),
    .wordCount(word_count_l)
`ifdef OUTPUT_DESER_OVERRUN_EN
    , .overrun(overrun_l)
`endif
  );

  output_deserializer #(
    .numWords(NW), .dataWidth(DW), .counterWidth(CW), .msbFirst(1)
  ) dut_msb (
    .clk(clk), .reset(reset), .clear(clear),
    .inValid(in_valid), .inData(in_data), .inReady(in_ready_m),
    .outValid(out_valid_m), .outReady(out_ready), .outData(out_data_m),
    .wordCount(word_count_m)
`ifdef OUTPUT_DESER_OVERRUN_EN
    , .overrun(overrun_m)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic        vld;
    logic [15:0] dat;
    logic        ordy;
    logic        e_irdy;
    logic        e_oval;
    logic [1:0]  e_wc;
    logic [63:0] e_lsb;
    logic [63:0] e_msb;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v,
                      input logic [15:0] d, input logic o);
    reset = r; clear = c; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic irdy, input logic oval,
                           input logic [1:0] wc, input logic [63:0] dl, input logic [63:0] dm);
    check({tag, ".inReady_l"},   64'(in_ready_l),   64'(irdy));
    check({tag, ".inReady_m"},   64'(in_ready_m),   64'(irdy));
    check({tag, ".outValid_l"},  64'(out_valid_l),  64'(oval));
    check({tag, ".outValid_m"},  64'(out_valid_m),  64'(oval));
    check({tag, ".wordCount_l"}, 64'(word_count_l), 64'(wc));
    check({tag, ".wordCount_m"}, 64'(word_count_m), 64'(wc));
    check({tag, ".outData_l"},   out_data_l,        dl);
    check({tag, ".outData_m"},   out_data_m,        dm);
  endtask

  initial begin
    // rst_n clr vld dat ordy | irdy oval wc lsb-first data / msb-first data
    vecs[0]  = '{0,0,0,16'h0000,0, 1,0,0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[1]  = '{1,0,1,16'h0001,0, 1,0,1, 64'h0000_0000_0000_0001, 64'h0001_0000_0000_0000};
    vecs[2]  = '{1,0,1,16'h0002,0, 1,0,2, 64'h0000_0000_0002_0001, 64'h0001_0002_0000_0000};
    vecs[3]  = '{1,0,1,16'h0003,0, 1,0,3, 64'h0000_0003_0002_0001, 64'h0001_0002_0003_0000};
    vecs[4]  = '{1,0,1,16'h0004,0, 0,1,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    // hold in FULL with outReady=0 for 5 cycles
    vecs[5]  = '{1,0,0,16'hDEAD,0, 0,1,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    vecs[6]  = '{1,0,0,16'hBEEF,0, 0,1,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    vecs[7]  = '{1,0,0,16'hCAFE,0, 0,1,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    vecs[8]  = '{1,0,0,16'h1234,0, 0,1,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    vecs[9]  = '{1,0,0,16'h5678,0, 0,1,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    vecs[10] = '{1,0,0,16'h0000,1, 1,0,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    vecs[11] = '{1,0,0,16'hBEEF,0, 1,0,0, 64'h0004_0003_0002_0001, 64'h0001_0002_0003_0004};
    // two captures then clear (clear beats the capture on the same edge)
    vecs[12] = '{1,0,1,16'h0011,0, 1,0,1, 64'h0004_0003_0002_0011, 64'h0011_0002_0003_0004};
    vecs[13] = '{1,0,1,16'h0022,0, 1,0,2, 64'h0004_0003_0022_0011, 64'h0011_0022_0003_0004};
    vecs[14] = '{1,1,1,16'h0099,0, 1,0,0, 64'h0004_0003_0022_0011, 64'h0011_0022_0003_0004};
    vecs[15] = '{1,0,1,16'h00A1,0, 1,0,1, 64'h0004_0003_0022_00A1, 64'h00A1_0022_0003_0004};
    vecs[16] = '{1,0,1,16'h00A2,0, 1,0,2, 64'h0004_0003_00A2_00A1, 64'h00A1_00A2_0003_0004};
    vecs[17] = '{1,0,1,16'h00A3,0, 1,0,3, 64'h0004_00A3_00A2_00A1, 64'h00A1_00A2_00A3_0004};
    vecs[18] = '{1,0,1,16'h00A4,0, 0,1,0, 64'h00A4_00A3_00A2_00A1, 64'h00A1_00A2_00A3_00A4};
    // transfer while a word is offered: no capture in FULL
    vecs[19] = '{1,0,1,16'h0055,1, 1,0,0, 64'h00A4_00A3_00A2_00A1, 64'h00A1_00A2_00A3_00A4};
    // three captures then reset (overrides clear and handshake)
    vecs[20] = '{1,0,1,16'h0001,0, 1,0,1, 64'h00A4_00A3_00A2_0001, 64'h0001_00A2_00A3_00A4};
    vecs[21] = '{1,0,1,16'h0002,0, 1,0,2, 64'h00A4_00A3_0002_0001, 64'h0001_0002_00A3_00A4};
    vecs[22] = '{1,0,1,16'h0003,0, 1,0,3, 64'h00A4_0003_0002_0001, 64'h0001_0002_0003_00A4};
    vecs[23] = '{0,1,1,16'h0004,1, 1,0,0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    vecs[24] = '{1,0,0,16'h0000,0, 1,0,0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].rst_n, vecs[i].clr, vecs[i].vld, vecs[i].dat, vecs[i].ordy);
      check_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_oval,
                vecs[i].e_wc, vecs[i].e_lsb, vecs[i].e_msb);
    end

    // Continuous traffic: word value = edge number; one vector every 5 edges.
    for (int e = 1; e <= 15; e++) begin
      step(1'b1, 1'b0, 1'b1, 16'(e), 1'b1);
      check($sformatf("stream%0d.outValid", e), 64'(out_valid_l), 64'((e % 5) == 4));
      if (e == 9) begin
        check("stream9.outData_l", out_data_l, 64'h0009_0008_0007_0006);
        check("stream9.outData_m", out_data_m, 64'h0006_0007_0008_0009);
      end
    end

    // Fill a vector, offer words while FULL, then clear out of FULL.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 16'(16'h0100 + k), 1'b0);
    end
    check("fill.outValid", 64'(out_valid_l), 64'd1);
    step(1'b1, 1'b0, 1'b1, 16'h7777, 1'b0);
    step(1'b1, 1'b0, 1'b1, 16'h8888, 1'b0);
    check("fullhold.outData_l", out_data_l, 64'h0103_0102_0101_0100);
`ifdef OUTPUT_DESER_OVERRUN_EN
    check("overrun.set_l", 64'(overrun_l), 64'd1);
    check("overrun.set_m", 64'(overrun_m), 64'd1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    check("overrun.sticky", 64'(overrun_l), 64'd1);
`endif
    step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    check_all("clearfull", 1'b1, 1'b0, 2'd0, 64'h0103_0102_0101_0100, 64'h0100_0101_0102_0103);
`ifdef OUTPUT_DESER_OVERRUN_EN
    check("overrun.cleared", 64'(overrun_l), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_output_deserializer
`default_nettype wire
